// File: rtl/pipe_front_regs_if.sv
// Signal bundle between the MIPS front-end pipeline registers and the fetch/hazard/decode logic.
// With PIPE_STALL_CNT_EN defined the bundle also carries the stall/flush event counters.
interface pipe_front_regs_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] imem_instr_i;
  logic              pc_write_i;
  logic              if_id_write_i;
  logic              stall_i;
  logic              branch_taken_i;
  logic [DATA_W-1:0] branch_target_i;
  logic              dec_reg_write_i;
  logic              dec_mem_read_i;
  logic              dec_mem_write_i;
  logic              dec_alu_src_i;

  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] if_id_instr_o;
  logic [DATA_W-1:0] if_id_pc4_o;
  logic [5:0]        opcode_o;
  logic [4:0]        if_id_rs_o;
  logic [4:0]        if_id_rt_o;
  logic              id_ex_reg_write_o;
  logic              id_ex_mem_read_o;
  logic              id_ex_mem_write_o;
  logic              id_ex_alu_src_o;
  logic [4:0]        id_ex_rt_o;
  logic [4:0]        id_ex_rd_o;
  logic              ex_mem_mem_read_o;
  logic              ex_mem_reg_write_o;
  logic [4:0]        ex_mem_rt_o;
  logic              protocol_err_o;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
  logic [15:0]       flush_cnt_o;
`endif

  modport slave (
`ifdef PIPE_STALL_CNT_EN
    output stall_cnt_o, flush_cnt_o,
`endif
    input  imem_instr_i, pc_write_i, if_id_write_i, stall_i, branch_taken_i,
           branch_target_i, dec_reg_write_i, dec_mem_read_i, dec_mem_write_i,
           dec_alu_src_i,
    output pc_o, if_id_instr_o, if_id_pc4_o, opcode_o, if_id_rs_o, if_id_rt_o,
           id_ex_reg_write_o, id_ex_mem_read_o, id_ex_mem_write_o, id_ex_alu_src_o,
           id_ex_rt_o, id_ex_rd_o, ex_mem_mem_read_o, ex_mem_reg_write_o,
           ex_mem_rt_o, protocol_err_o
  );

  modport master (
`ifdef PIPE_STALL_CNT_EN
    input  stall_cnt_o, flush_cnt_o,
`endif
    output imem_instr_i, pc_write_i, if_id_write_i, stall_i, branch_taken_i,
           branch_target_i, dec_reg_write_i, dec_mem_read_i, dec_mem_write_i,
           dec_alu_src_i,
    input  pc_o, if_id_instr_o, if_id_pc4_o, opcode_o, if_id_rs_o, if_id_rt_o,
           id_ex_reg_write_o, id_ex_mem_read_o, id_ex_mem_write_o, id_ex_alu_src_o,
           id_ex_rt_o, id_ex_rd_o, ex_mem_mem_read_o, ex_mem_reg_write_o,
           ex_mem_rt_o, protocol_err_o
  );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS front end.
// Optional stall/flush counters are built when PIPE_STALL_CNT_EN is defined.
module pipe_front_regs #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_front_regs_if.slave bus
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [4:0] rt;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       mem_read;
    logic       reg_write;
    logic [4:0] rt;
  } ex_mem_t;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] if_id_instr;
  logic [DATA_W-1:0] if_id_pc4;
  logic              if_id_valid;
  logic              br_eff;
  logic              ctl_bad;
  logic              protocol_err;
  id_ex_t            id_ex;
  id_ex_t            id_ex_next;
  ex_mem_t           ex_mem;

  assign pc_plus4 = pc + DATA_W'(4);
  // A branch is only honoured when the hazard unit is not stalling and IF/ID holds a real instruction.
  assign br_eff   = bus.branch_taken_i & ~bus.stall_i & if_id_valid;
  assign ctl_bad  = (bus.pc_write_i == bus.stall_i) | (bus.if_id_write_i == bus.stall_i);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    id_ex_next = '0;
    if (!bus.stall_i && if_id_valid) begin
      id_ex_next.reg_write = bus.dec_reg_write_i;
      id_ex_next.mem_read  = bus.dec_mem_read_i;
      id_ex_next.mem_write = bus.dec_mem_write_i;
      id_ex_next.alu_src   = bus.dec_alu_src_i;
      id_ex_next.rt        = if_id_instr[20:16];
      id_ex_next.rd        = bus.dec_alu_src_i ? if_id_instr[20:16] : if_id_instr[15:11];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (br_eff) begin
      pc          <= bus.branch_target_i;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      if (bus.pc_write_i) pc <= pc_plus4;
      if (bus.if_id_write_i) begin
        if_id_instr <= bus.imem_instr_i;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex  <= '0;
      ex_mem <= '0;
    end else begin
      id_ex  <= id_ex_next;
      ex_mem <= '{mem_read: id_ex.mem_read, reg_write: id_ex.reg_write, rt: id_ex.rt};
    end
  end

  // Sticky: once the stall controls disagree, only reset clears the flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       protocol_err <= 1'b0;
    else if (ctl_bad) protocol_err <= 1'b1;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall_i && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (br_eff && flush_cnt != 16'hFFFF)      flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`endif

  assign bus.pc_o               = pc;
  assign bus.if_id_instr_o      = if_id_instr;
  assign bus.if_id_pc4_o        = if_id_pc4;
  assign bus.opcode_o           = if_id_instr[31:26];
  assign bus.if_id_rs_o         = if_id_instr[25:21];
  assign bus.if_id_rt_o         = if_id_instr[20:16];
  assign bus.id_ex_reg_write_o  = id_ex.reg_write;
  assign bus.id_ex_mem_read_o   = id_ex.mem_read;
  assign bus.id_ex_mem_write_o  = id_ex.mem_write;
  assign bus.id_ex_alu_src_o    = id_ex.alu_src;
  assign bus.id_ex_rt_o         = id_ex.rt;
  assign bus.id_ex_rd_o         = id_ex.rd;
  assign bus.ex_mem_mem_read_o  = ex_mem.mem_read;
  assign bus.ex_mem_reg_write_o = ex_mem.reg_write;
  assign bus.ex_mem_rt_o        = ex_mem.rt;
  assign bus.protocol_err_o     = protocol_err;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: a stage-record reference model predicts each edge,
// a monitor pops predictions and compares them with the outputs one time unit after the edge.
module tb_pipe_front_regs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  pipe_front_regs_if #(.DATA_W(32)) bus ();
  pipe_front_regs #(.DATA_W(32), .RESET_PC(RESET_PC)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  logic [31:0] imem [256];
  assign bus.imem_instr_i = imem[bus.pc_o[9:2]];

  typedef struct packed {
    logic st, pcw, ifw, br;
    logic [31:0] tgt;
    logic rw, mr, mw, as;
  } stim_t;

  // Architectural view: one record per pipeline slot plus the PC and bookkeeping.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] f_instr;
    logic [31:0] f_pc4;
    logic        f_valid;
    logic        d_rw, d_mr, d_mw, d_as;
    logic [4:0]  d_rt, d_rd;
    logic        m_mr, m_rw;
    logic [4:0]  m_rt;
    logic        perr;
    logic [15:0] scnt, fcnt;
  } model_t;

  model_t model;
  model_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m = '0;
    m.pc = RESET_PC;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, stim_t s);
    model_t n = m;
    logic take = s.br && !s.st && m.f_valid;
    logic [31:0] word = imem[m.pc[9:2]];
    // The instruction leaving ID either advances or becomes a bubble.
    {n.m_mr, n.m_rw, n.m_rt} = {m.d_mr, m.d_rw, m.d_rt};
    if (s.st || !m.f_valid) begin
      {n.d_rw, n.d_mr, n.d_mw, n.d_as, n.d_rt, n.d_rd} = '0;
    end else begin
      {n.d_rw, n.d_mr, n.d_mw, n.d_as} = {s.rw, s.mr, s.mw, s.as};
      n.d_rt = m.f_instr[20:16];
      n.d_rd = s.as ? m.f_instr[20:16] : m.f_instr[15:11];
    end
    if (take) begin
      n.pc = s.tgt;
      {n.f_instr, n.f_pc4, n.f_valid} = '0;
    end else begin
      if (s.pcw) n.pc = m.pc + 32'd4;
      if (s.ifw) begin
        n.f_instr = word;
        n.f_pc4   = m.pc + 32'd4;
        n.f_valid = 1'b1;
      end
    end
    if (s.pcw == s.st || s.ifw == s.st) n.perr = 1'b1;
    if (s.st && m.scnt < 16'hFFFF) n.scnt = m.scnt + 16'd1;
    if (take && m.fcnt < 16'hFFFF) n.fcnt = m.fcnt + 16'd1;
    return n;
  endfunction

  function automatic stim_t s_norm(input logic [3:0] dec);
    stim_t s = '0;
    s.pcw = 1'b1;
    s.ifw = 1'b1;
    {s.rw, s.mr, s.mw, s.as} = dec;
    return s;
  endfunction

  function automatic stim_t s_stall(input logic br, input logic [31:0] tgt);
    stim_t s = '0;
    s.st  = 1'b1;
    s.br  = br;
    s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t s_br(input logic [31:0] tgt);
    stim_t s = s_norm(4'($urandom_range(0, 15)));
    s.br  = 1'b1;
    s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = s_norm(4'($urandom_range(0, 15)));
    int mode = int'($urandom_range(0, 19));
    if (mode == 0) begin
      {s.st, s.pcw, s.ifw} = 3'($urandom_range(0, 7));
    end else if (mode <= 4) begin
      {s.st, s.pcw, s.ifw} = 3'b100;
    end
    s.br = ($urandom_range(0, 5) == 0);
    s.tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 255)) << 2;
    return s;
  endfunction

  // Applies one stimulus in the low clock phase, predicts the edge, returns 2 units after it.
  task automatic cycle(input stim_t s);
    @(negedge clk_i);
    bus.stall_i         = s.st;
    bus.pc_write_i      = s.pcw;
    bus.if_id_write_i   = s.ifw;
    bus.branch_taken_i  = s.br;
    bus.branch_target_i = s.tgt;
    {bus.dec_reg_write_i, bus.dec_mem_read_i, bus.dec_mem_write_i, bus.dec_alu_src_i} =
      {s.rw, s.mr, s.mw, s.as};
    model = model_next(model, s);
    sb_q.push_back(model);
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, bus.pc_o, RESET_PC);
    check({tag, "_instr"}, bus.if_id_instr_o, 32'h0);
    check({tag, "_pc4"}, bus.if_id_pc4_o, 32'h0);
    check({tag, "_idex"}, 32'({bus.id_ex_reg_write_o, bus.id_ex_mem_read_o, bus.id_ex_mem_write_o,
                                bus.id_ex_alu_src_o, bus.id_ex_rt_o, bus.id_ex_rd_o}), 32'h0);
    check({tag, "_exmem"}, 32'({bus.ex_mem_mem_read_o, bus.ex_mem_reg_write_o, bus.ex_mem_rt_o}), 32'h0);
    check({tag, "_perr"}, 32'(bus.protocol_err_o), 32'h0);
`ifdef PIPE_STALL_CNT_EN
    check({tag, "_cnts"}, {bus.stall_cnt_o, bus.flush_cnt_o}, 32'h0);
`endif
  endtask

  // Called 2 units after an edge, so the asserting edge of rst_i lands between clock edges.
  task automatic do_reset();
    bus.stall_i = 1'b0;
    bus.pc_write_i = 1'b0;
    bus.if_id_write_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_target_i = '0;
    {bus.dec_reg_write_i, bus.dec_mem_read_i, bus.dec_mem_write_i, bus.dec_alu_src_i} = '0;
    #1 rst_i = 1'b0;
    #1;
    model = model_reset();
    check_reset("rst_async");
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_reset("rst_release");
  endtask

  initial begin : monitor
    model_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc", bus.pc_o, e.pc);
        check("if_id_instr", bus.if_id_instr_o, e.f_instr);
        check("if_id_pc4", bus.if_id_pc4_o, e.f_pc4);
        check("opcode", 32'(bus.opcode_o), 32'(e.f_instr[31:26]));
        check("if_id_rs", 32'(bus.if_id_rs_o), 32'(e.f_instr[25:21]));
        check("if_id_rt", 32'(bus.if_id_rt_o), 32'(e.f_instr[20:16]));
        check("id_ex_ctl", 32'({bus.id_ex_reg_write_o, bus.id_ex_mem_read_o, bus.id_ex_mem_write_o,
                                bus.id_ex_alu_src_o}), 32'({e.d_rw, e.d_mr, e.d_mw, e.d_as}));
        check("id_ex_rt", 32'(bus.id_ex_rt_o), 32'(e.d_rt));
        check("id_ex_rd", 32'(bus.id_ex_rd_o), 32'(e.d_rd));
        check("ex_mem", 32'({bus.ex_mem_mem_read_o, bus.ex_mem_reg_write_o, bus.ex_mem_rt_o}),
              32'({e.m_mr, e.m_rw, e.m_rt}));
        check("protocol_err", 32'(bus.protocol_err_o), 32'(e.perr));
`ifdef PIPE_STALL_CNT_EN
        check("stall_cnt", 32'(bus.stall_cnt_o), 32'(e.scnt));
        check("flush_cnt", 32'(bus.flush_cnt_o), 32'(e.fcnt));
`endif
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h8D28_0000;  // lw $8, 0($9)
    model = model_reset();
    do_reset();

    // Load-use: lw reaches ID/EX, then one stall cycle.
    cycle(s_norm(4'b0000));
    cycle(s_norm(4'b1101));
    check("lu_idex_mr_before", 32'(bus.id_ex_mem_read_o), 32'h1);
    check("lu_idex_rt_before", 32'(bus.id_ex_rt_o), 32'd8);
    cycle(s_stall(1'b0, 32'h0));
    check("lu_pc_hold", bus.pc_o, 32'h8);
    check("lu_idex_mr", 32'(bus.id_ex_mem_read_o), 32'h0);
    check("lu_idex_rt", 32'(bus.id_ex_rt_o), 32'h0);
    check("lu_exmem_mr", 32'(bus.ex_mem_mem_read_o), 32'h1);
    check("lu_exmem_rt", 32'(bus.ex_mem_rt_o), 32'd8);

    // Taken branch from pc 0x10 to 0x40, then the bubble in ID/EX.
    cycle(s_norm(4'b0000));
    cycle(s_norm(4'b0000));
    check("beq_pc_before", bus.pc_o, 32'h10);
    cycle(s_br(32'h40));
    check("beq_pc", bus.pc_o, 32'h40);
    check("beq_flush", bus.if_id_instr_o, 32'h0);
    cycle(s_norm(4'b1111));
    check("beq_bubble", 32'({bus.id_ex_reg_write_o, bus.id_ex_mem_read_o, bus.id_ex_rt_o,
                              bus.id_ex_rd_o}), 32'h0);

    // Branch presented during a stall is ignored, then taken once the stall lifts.
    cycle(s_stall(1'b1, 32'h80));
    check("bstall_pc", bus.pc_o, 32'h44);
    check("bstall_noflush", bus.if_id_instr_o, imem[16]);
    cycle(s_br(32'h80));
    check("bstall_taken", bus.pc_o, 32'h80);

    // Inconsistent stall controls raise the sticky error.
    begin
      stim_t s = s_norm(4'b0000);
      s.pcw = 1'b0;
      cycle(s);
    end
    check("perr_set", 32'(bus.protocol_err_o), 32'h1);
    cycle(s_norm(4'b0000));
    check("perr_sticky", 32'(bus.protocol_err_o), 32'h1);

    // PC wrap past the top of the address space.
    cycle(s_br(32'hFFFF_FFFC));
    cycle(s_norm(4'b0000));
    check("wrap_pc", bus.pc_o, 32'h0);
    check("wrap_pc4", bus.if_id_pc4_o, 32'h0);

    // Reset mid-run from pc 0x20 clears everything, including the sticky error.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(s_norm(4'($urandom_range(0, 15))));
    check("mid_pc", bus.pc_o, 32'h20);
    do_reset();

    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 300; i++) cycle(rand_stim());
      do_reset();
    end

`ifdef PIPE_STALL_CNT_EN
    cycle(s_norm(4'b0000));
    for (int i = 0; i < 3; i++) cycle(s_stall(1'b0, 32'h0));
    cycle(s_br(32'h100));
    cycle(s_norm(4'b0000));
    cycle(s_br(32'h200));
    check("cnt_stall3", 32'(bus.stall_cnt_o), 32'd3);
    check("cnt_flush2", 32'(bus.flush_cnt_o), 32'd2);
    for (int i = 0; i < 65535; i++) cycle(s_stall(1'b0, 32'h0));
    check("cnt_sat", 32'(bus.stall_cnt_o), 32'h0000_FFFF);
    cycle(s_stall(1'b0, 32'h0));
    check("cnt_sat_hold", 32'(bus.stall_cnt_o), 32'h0000_FFFF);
`endif

    repeat (2) @(posedge clk_i);
    #3 check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
